// File: rtl/aes_core_arbiter_pkg.sv
// aes_core_arbiter_pkg
// Shared definitions for the AES core arbiter:
//   - word/block geometry (WORD_S bits per word, NB words per block)
//   - bit positions inside a requester command word
//   - arbiter FSM state encoding
//   - idx_width(): index width for a requester count, at least 1 bit
package aes_core_arbiter_pkg;

  localparam int WORD_S = 32;
  localparam int NB     = 4;

  localparam int AES_CMD_ENCRYPT_BIT = 0;
  localparam int AES_CMD_KEY_NEW_BIT = 1;

  typedef enum logic [2:0] {
    AES_ARB_IDLE  = 3'd0,
    AES_ARB_GRANT = 3'd1,
    AES_ARB_KEY   = 3'd2,
    AES_ARB_RUN   = 3'd3,
    AES_ARB_RESP  = 3'd4
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aes_core_arbiter_rr_arbiter.sv
// aes_core_arbiter_rr_arbiter
// Combinational round-robin picker. Scans the request vector starting at
// ptr and wrapping modulo N_REQ; the first set request wins.
// Ports:
//   req       in  N_REQ  request vector
//   ptr       in  IDX_W  index with highest priority this round
//   grant     out N_REQ  one-hot grant (all zero when no request)
//   grant_idx out IDX_W  index of the granted requester
//   any       out 1      at least one request is set
module aes_core_arbiter_rr_arbiter
  import aes_core_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  // Walk offsets from farthest to nearest so the request closest to ptr
  // is the last one written and therefore wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i] && (i == ((int'(ptr) + off) % N_REQ))) begin
          grant     = '0;
          grant[i]  = 1'b1;
          grant_idx = IDX_W'(i);
          any       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter
// Shares one AES block-cipher core between N_REQ requesters, one 128-bit
// block per transaction. Round-robin grant, optional key expansion, then a
// single block operation whose result is returned to the granted requester.
//
// Build option: AES_ARB_KEY_CACHE_EN
//   defined   - remember which requester's key is expanded in the core and
//               skip expansion when the same requester asks again without
//               KEY_NEW
//   undefined - every transaction expands its key
//
// Ports:
//   clk, aresetn          clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester request and one-cycle grant strobe
//   req_cmd/key/data      per-requester command word, key and input block
//   rsp_valid/rsp_ready   per-requester result handshake
//   rsp_data              shared result bus
//   core_key_start/done   key expansion handshake with the core
//   core_start/done       block operation handshake with the core
//   core_encrypt          1 = encrypt, 0 = decrypt
//   core_key/core_data    operands to the core
//   core_result           core output, valid while core_done is high
//
// state | meaning
// IDLE  | no transaction; wait for any request
// GRANT | pick requester, strobe req_ready, capture operands
// KEY   | key expansion running in the core
// RUN   | block operation running in the core
// RESP  | result presented until the granted requester accepts it
module aes_core_arbiter
  import aes_core_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int CMD_W = WORD_S,
  parameter int BLK_W = NB * WORD_S
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*CMD_W-1:0] req_cmd,
  input  logic [N_REQ*BLK_W-1:0] req_key,
  input  logic [N_REQ*BLK_W-1:0] req_data,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [BLK_W-1:0]       rsp_data,
  output logic                   core_key_start,
  input  logic                   core_key_done,
  output logic                   core_start,
  output logic                   core_encrypt,
  output logic [BLK_W-1:0]       core_key,
  output logic [BLK_W-1:0]       core_data,
  input  logic                   core_done,
  input  logic [BLK_W-1:0]       core_result
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  arb_state_e state_q, state_d;

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             encrypt_q, encrypt_d;
  logic [BLK_W-1:0] key_q, key_d;
  logic [BLK_W-1:0] data_q, data_d;
  logic [BLK_W-1:0] rsp_data_q, rsp_data_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic             key_start_q, key_start_d;
  logic             start_q, start_d;

  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;

  logic             sel_encrypt;
  logic             sel_key_new;
  logic [BLK_W-1:0] sel_key;
  logic [BLK_W-1:0] sel_data;
  logic             need_key;
  logic             rsp_accept;
  logic [N_REQ-1:0] req_ready_c;

  // Only two command bits are meaningful; the rest of the word is reserved.
  logic unused_req_cmd;
  assign unused_req_cmd = ^req_cmd;

  aes_core_arbiter_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // Operand mux for the requester currently winning arbitration.
  always_comb begin
    sel_encrypt = 1'b0;
    sel_key_new = 1'b0;
    sel_key     = '0;
    sel_data    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_encrypt = req_cmd[i*CMD_W + AES_CMD_ENCRYPT_BIT];
        sel_key_new = req_cmd[i*CMD_W + AES_CMD_KEY_NEW_BIT];
        sel_key     = req_key[i*BLK_W +: BLK_W];
        sel_data    = req_data[i*BLK_W +: BLK_W];
      end
    end
  end

`ifdef AES_ARB_KEY_CACHE_EN
  logic [IDX_W-1:0] key_owner_q, key_owner_d;
  logic             key_owner_valid_q, key_owner_valid_d;

  assign need_key = !key_owner_valid_q || (key_owner_q != arb_idx) || sel_key_new;

  // The expanded key belongs to whoever finished KEY last. A reset clears
  // ownership because the core loses its schedule too.
  always_comb begin
    key_owner_d       = key_owner_q;
    key_owner_valid_d = key_owner_valid_q;
    if ((state_q == AES_ARB_KEY) && core_key_done && !key_start_q) begin
      key_owner_d       = gnt_idx_q;
      key_owner_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      key_owner_q       <= '0;
      key_owner_valid_q <= 1'b0;
    end else begin
      key_owner_q       <= key_owner_d;
      key_owner_valid_q <= key_owner_valid_d;
    end
  end
`else
  logic unused_key_new;
  assign unused_key_new = sel_key_new;
  assign need_key       = 1'b1;
`endif

  always_comb begin
    rsp_accept = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if ((gnt_idx_q == IDX_W'(i)) && rsp_ready[i]) begin
        rsp_accept = 1'b1;
      end
    end
  end

  // Start pulses are registered and raised on the transition into KEY/RUN,
  // so a done pulse seen while the start flop is still high belongs to an
  // earlier operation and is ignored.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_idx_d   = gnt_idx_q;
    encrypt_d   = encrypt_q;
    key_d       = key_q;
    data_d      = data_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    key_start_d = 1'b0;
    start_d     = 1'b0;
    req_ready_c = '0;

    unique case (state_q)
      AES_ARB_IDLE: begin
        if (|req_valid) begin
          state_d = AES_ARB_GRANT;
        end
      end

      AES_ARB_GRANT: begin
        if (arb_any) begin
          req_ready_c = arb_grant;
          gnt_idx_d   = arb_idx;
          encrypt_d   = sel_encrypt;
          key_d       = sel_key;
          data_d      = sel_data;
          if (need_key) begin
            state_d     = AES_ARB_KEY;
            key_start_d = 1'b1;
          end else begin
            state_d = AES_ARB_RUN;
            start_d = 1'b1;
          end
        end else begin
          state_d = AES_ARB_IDLE;
        end
      end

      AES_ARB_KEY: begin
        if (core_key_done && !key_start_q) begin
          state_d = AES_ARB_RUN;
          start_d = 1'b1;
        end
      end

      AES_ARB_RUN: begin
        if (core_done && !start_q) begin
          rsp_data_d = core_result;
          for (int i = 0; i < N_REQ; i++) begin
            rsp_valid_d[i] = (gnt_idx_q == IDX_W'(i));
          end
          state_d = AES_ARB_RESP;
        end
      end

      AES_ARB_RESP: begin
        if (rsp_accept) begin
          rsp_valid_d = '0;
          rr_ptr_d    = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + 1'b1;
          state_d     = AES_ARB_IDLE;
        end
      end

      default: begin
        state_d = AES_ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= AES_ARB_IDLE;
      rr_ptr_q    <= '0;
      gnt_idx_q   <= '0;
      encrypt_q   <= 1'b0;
      key_q       <= '0;
      data_q      <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
      key_start_q <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      encrypt_q   <= encrypt_d;
      key_q       <= key_d;
      data_q      <= data_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      key_start_q <= key_start_d;
      start_q     <= start_d;
    end
  end

  assign req_ready      = req_ready_c;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign core_key_start = key_start_q;
  assign core_start     = start_q;
  assign core_encrypt   = encrypt_q;
  assign core_key       = key_q;
  assign core_data      = data_q;

endmodule

// File: tb/tb_aes_core_arbiter.sv
module tb_aes_core_arbiter;

  localparam int N_REQ = 2;
  localparam int CMD_W = 32;
  localparam int BLK_W = 128;

  localparam logic [31:0]  CMD_ENC = 32'h0000_0001;
  localparam logic [31:0]  CMD_KN  = 32'h0000_0002;
  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] D0 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] D1 = 128'h55555555_66666666_77777777_88888888;
  localparam logic [127:0] D2 = 128'h99999999_aaaaaaaa_bbbbbbbb_cccccccc;
  localparam logic [127:0] D3 = 128'hdddddddd_eeeeeeee_ffffffff_00000000;
  localparam logic [127:0] D4 = 128'h0123456789abcdef_fedcba9876543210;
  localparam logic [127:0] D5 = 128'hcafef00d_deadbeef_8badf00d_feedface;

`ifdef AES_ARB_KEY_CACHE_EN
  localparam int REUSE_KEYS = 0;
`else
  localparam int REUSE_KEYS = 1;
`endif

  logic                   clk;
  logic                   aresetn;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*CMD_W-1:0] req_cmd;
  logic [N_REQ*BLK_W-1:0] req_key;
  logic [N_REQ*BLK_W-1:0] req_data;
  logic [N_REQ-1:0]       rsp_valid;
  logic [N_REQ-1:0]       rsp_ready;
  logic [BLK_W-1:0]       rsp_data;
  logic                   core_key_start;
  logic                   core_key_done;
  logic                   core_start;
  logic                   core_encrypt;
  logic [BLK_W-1:0]       core_key;
  logic [BLK_W-1:0]       core_data;
  logic                   core_done;
  logic [BLK_W-1:0]       core_result;

  aes_core_arbiter #(
    .N_REQ (N_REQ),
    .CMD_W (CMD_W),
    .BLK_W (BLK_W)
  ) dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_cmd        (req_cmd),
    .req_key        (req_key),
    .req_data       (req_data),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .core_key_start (core_key_start),
    .core_key_done  (core_key_done),
    .core_start     (core_start),
    .core_encrypt   (core_encrypt),
    .core_key       (core_key),
    .core_data      (core_data),
    .core_done      (core_done),
    .core_result    (core_result)
  );

  int checks = 0;
  int errors = 0;
  int kstarts = 0;
  int starts = 0;
  int unsigned spur_req = 0;
  int unsigned spur_ack = 0;

  logic [127:0] exp_q0[$];
  logic [127:0] exp_q1[$];
  int           exp_grant_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stand-in for the AES core: the two FIPS-197 vectors map exactly, any
  // other operand gets a deterministic scramble so routing errors show up.
  function automatic logic [127:0] core_fn(input logic enc, input logic [127:0] k, input logic [127:0] d);
    if (k == K0 && enc && d == PT) return CT;
    if (k == K0 && !enc && d == CT) return PT;
    return d ^ k ^ (enc ? 128'h5a5a5a5a_a5a5a5a5_5a5a5a5a_a5a5a5a5 : 128'h0f0f0f0f_f0f0f0f0_0f0f0f0f_f0f0f0f0);
  endfunction

  // Core model: key done 3 cycles after key start, block done 4 cycles
  // after block start. Can also inject stray done pulses on request.
  initial begin : core_model
    int kcnt;
    int bcnt;
    logic [127:0] bres;
    kcnt = 0;
    bcnt = 0;
    bres = '0;
    core_key_done = 1'b0;
    core_done = 1'b0;
    core_result = '0;
    forever begin
      @(posedge clk);
      #1;
      core_key_done = 1'b0;
      core_done = 1'b0;
      if (!aresetn) begin
        kcnt = 0;
        bcnt = 0;
      end else begin
        if (spur_req != spur_ack) begin
          spur_ack = spur_req;
          core_done = 1'b1;
          core_key_done = 1'b1;
          core_result = 128'hbad0bad0_bad0bad0_bad0bad0_bad0bad0;
        end
        if (core_key_start) kcnt = 3;
        else if (kcnt > 0) begin
          kcnt--;
          if (kcnt == 0) core_key_done = 1'b1;
        end
        if (core_start) begin
          bcnt = 4;
          bres = core_fn(core_encrypt, core_key, core_data);
        end else if (bcnt > 0) begin
          bcnt--;
          if (bcnt == 0) begin
            core_done = 1'b1;
            core_result = bres;
          end
        end
      end
    end
  end

  // Monitor: grant order, start latencies, response scoreboard.
  initial begin : monitor
    logic [N_REQ-1:0] prev_rr;
    logic [N_REQ-1:0] prev_rv;
    logic             prev_kd;
    logic             prev_cd;
    logic [N_REQ-1:0] one_g;
    logic [127:0]     e;
    int               g;
    prev_rr = '0;
    prev_rv = '0;
    prev_kd = 1'b0;
    prev_cd = 1'b0;
    forever begin
      @(negedge clk);
      if (aresetn) begin
        if (req_ready != '0) begin
          check("grant_onehot", 128'($onehot(req_ready)), 128'd1);
          if (exp_grant_q.size() == 0) check("grant_unexpected", 128'(req_ready), 128'd0);
          else begin
            g = exp_grant_q.pop_front();
            one_g = 2'b01 << g;
            check("grant_order", 128'(req_ready), 128'(one_g));
          end
        end
        if (core_key_start) begin
          kstarts++;
          check("key_start_after_grant", 128'(prev_rr != '0), 128'd1);
        end
        if (core_start) begin
          starts++;
          check("start_latency", 128'((prev_rr != '0) || prev_kd), 128'd1);
        end
        if (rsp_valid != '0 && prev_rv == '0) check("rsp_latency", 128'(prev_cd), 128'd1);
        if (rsp_valid != '0) check("rsp_onehot", 128'($onehot(rsp_valid)), 128'd1);
        if (rsp_valid[0] && rsp_ready[0]) begin
          if (exp_q0.size() == 0) check("rsp0_unexpected", rsp_data, 128'd0);
          else begin
            e = exp_q0.pop_front();
            check("rsp0_data", rsp_data, e);
          end
        end
        if (rsp_valid[1] && rsp_ready[1]) begin
          if (exp_q1.size() == 0) check("rsp1_unexpected", rsp_data, 128'd0);
          else begin
            e = exp_q1.pop_front();
            check("rsp1_data", rsp_data, e);
          end
        end
      end
      prev_rr = req_ready;
      prev_rv = rsp_valid;
      prev_kd = core_key_done;
      prev_cd = core_done;
    end
  end

  task automatic send(input int idx, input logic [31:0] cmd, input logic [127:0] k,
                      input logic [127:0] d, input logic [127:0] exp);
    bit got;
    if (idx == 0) exp_q0.push_back(exp);
    else exp_q1.push_back(exp);
    req_cmd[idx*CMD_W +: CMD_W] = cmd;
    req_key[idx*BLK_W +: BLK_W] = k;
    req_data[idx*BLK_W +: BLK_W] = d;
    req_valid[idx] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (req_ready[idx]) got = 1'b1;
    end
    check("grant_wait", 128'(got), 128'd1);
    @(posedge clk);
    #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || req_valid != '0 || rsp_valid != '0) && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("drain", 128'(c < 500), 128'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, 128'({req_ready, rsp_valid, core_key_start, core_start, core_encrypt}), 128'd0);
    check({tag, "_core_key"}, core_key, 128'd0);
    check({tag, "_core_data"}, core_data, 128'd0);
    check({tag, "_rsp_data"}, rsp_data, 128'd0);
  endtask

  initial begin : stim
    int kb;
    int sb;
    bit got;
    bit quiet;

    aresetn = 1'b0;
    req_valid = '0;
    req_cmd = '0;
    req_key = '0;
    req_data = '0;
    rsp_ready = 2'b11;
    repeat (2) @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1 aresetn = 1'b1;
    repeat (2) @(negedge clk);

    // single encrypt, FIPS-197 vector
    kb = kstarts; sb = starts;
    exp_grant_q.push_back(0);
    send(0, CMD_ENC, K0, PT, CT);
    drain();
    check("single_key_starts", 128'(kstarts - kb), 128'd1);
    check("single_starts", 128'(starts - sb), 128'd1);

    // same owner, no KEY_NEW
    kb = kstarts; sb = starts;
    exp_grant_q.push_back(0);
    send(0, CMD_ENC, K0, PT, CT);
    drain();
    check("reuse_key_starts", 128'(kstarts - kb), 128'(REUSE_KEYS));
    check("reuse_starts", 128'(starts - sb), 128'd1);

    // KEY_NEW forces expansion
    kb = kstarts;
    exp_grant_q.push_back(0);
    send(0, CMD_ENC | CMD_KN, K0, PT, CT);
    drain();
    check("keynew_key_starts", 128'(kstarts - kb), 128'd1);

    // stray done pulses while idle
    spur_req++;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid != '0 || core_start || core_key_start || req_ready != '0) quiet = 1'b0;
    end
    check("stray_done_ignored", 128'(quiet), 128'd1);
    check("stray_done_rsp_data", rsp_data, CT);

    // decrypt on requester 1
    kb = kstarts;
    exp_grant_q.push_back(1);
    send(1, 32'h0, K0, CT, PT);
    drain();
    check("decrypt_key_starts", 128'(kstarts - kb), 128'd1);

    // fairness: both requesters hold valid for two transactions each
    kb = kstarts; sb = starts;
    exp_grant_q.push_back(0);
    exp_grant_q.push_back(1);
    exp_grant_q.push_back(0);
    exp_grant_q.push_back(1);
    fork
      begin
        send(0, CMD_ENC, K0, D0, core_fn(1'b1, K0, D0));
        send(0, CMD_ENC, K0, D2, core_fn(1'b1, K0, D2));
      end
      begin
        send(1, CMD_ENC, K0, D1, core_fn(1'b1, K0, D1));
        send(1, CMD_ENC, K0, D3, core_fn(1'b1, K0, D3));
      end
    join
    drain();
    check("fair_key_starts", 128'(kstarts - kb), 128'd4);
    check("fair_starts", 128'(starts - sb), 128'd4);

    // backpressure on requester 1 while requester 0 waits
    rsp_ready = 2'b01;
    exp_grant_q.push_back(1);
    exp_grant_q.push_back(0);
    fork
      send(1, CMD_ENC | CMD_KN, K1, D4, core_fn(1'b1, K1, D4));
      begin
        repeat (2) @(posedge clk);
        #1;
        send(0, CMD_ENC, K0, D5, core_fn(1'b1, K0, D5));
      end
    join_none
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (rsp_valid[1]) got = 1'b1;
    end
    check("bp_rsp_seen", 128'(got), 128'd1);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_ctrl", 128'({rsp_valid, req_ready, core_key_start, core_start}), 128'({2'b10, 2'b00, 1'b0, 1'b0}));
      check("bp_hold_data", rsp_data, core_fn(1'b1, K1, D4));
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 2'b11;
    drain();

    // reset while the core is running
    exp_grant_q.push_back(0);
    req_cmd[0 +: CMD_W] = CMD_ENC;
    req_key[0 +: BLK_W] = K0;
    req_data[0 +: BLK_W] = PT;
    req_valid[0] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (req_ready[0]) got = 1'b1;
    end
    check("abort_grant_wait", 128'(got), 128'd1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (core_start) got = 1'b1;
    end
    check("abort_run_seen", 128'(got), 128'd1);
    @(posedge clk);
    #1 aresetn = 1'b0;
    @(negedge clk);
    check_zero("midrun_reset");
    @(posedge clk);
    @(posedge clk);
    #1 aresetn = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_idle", 128'({rsp_valid, core_start, core_key_start}), 128'd0);

    kb = kstarts; sb = starts;
    exp_grant_q.push_back(0);
    send(0, CMD_ENC, K0, PT, CT);
    drain();
    check("post_reset_key_starts", 128'(kstarts - kb), 128'd1);
    check("post_reset_starts", 128'(starts - sb), 128'd1);
    check("grant_queue_empty", 128'(exp_grant_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Shares one AES block-cipher core between N_REQ independent requesters (e.g. two AXI-stream channels), one 128-bit block per transaction.
- Round-robin arbitration; sequences key expansion (only when needed) then block encrypt/decrypt; routes the result back to the granted requester.
- Sits between the per-channel stream front-ends and the single aes_top core instance.

Parameters:
- N_REQ, 2, number of requesters (1..4)
- CMD_W, 32, command word width (`WORD_S)
- BLK_W, 128, block/key width (`Nb*`WORD_S)

Ports:
- clk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  request pending, per requester
- req_ready  out  N_REQ  one-cycle grant/capture strobe
- req_cmd  in  N_REQ*CMD_W  per-requester command (ENCRYPT bit, KEY_NEW bit)
- req_key  in  N_REQ*BLK_W  per-requester key
- req_data  in  N_REQ*BLK_W  per-requester input block
- rsp_valid  out  N_REQ  result valid, per requester
- rsp_ready  in  N_REQ  result accepted
- rsp_data  out  BLK_W  result block (shared bus)
- core_key_start  out  1  key-expansion start pulse
- core_key_done  in  1  key expansion complete pulse
- core_start  out  1  block operation start pulse
- core_encrypt  out  1  1=encrypt, 0=decrypt
- core_key  out  BLK_W  key to core
- core_data  out  BLK_W  block to core
- core_done  in  1  block complete pulse
- core_result  in  BLK_W  core output, valid while core_done=1

Behaviour:
- Reset (async, aresetn=0): state=IDLE; all outputs 0; rr_ptr=0; key_owner_valid=0. Reset mid-operation abandons the transaction with no response; the core shares the reset.
- States: IDLE, GRANT, KEY, RUN, RESP.
- IDLE: if any req_valid -> GRANT.
- GRANT (1 cycle): pick the first set req_valid scanning from rr_ptr upward, modulo N_REQ. Pulse req_ready[g]=1 this cycle. Capture cmd/key/data into internal regs and store g. If all req_valid have dropped -> IDLE, no strobe. Requesters hold valid until the ready strobe.
- Key decision, evaluated in GRANT: need_key = !key_owner_valid | (key_owner!=g) | cmd.KEY_NEW. If need_key -> KEY, else -> RUN.
- KEY: core_key_start pulses 1 cycle on entry. Wait for core_key_done; a core_key_done in the same cycle as the start pulse is ignored. Then key_owner=g, key_owner_valid=1 -> RUN.
- RUN: core_start pulses 1 cycle on entry; core_encrypt=cmd.ENCRYPT. core_key/core_data driven from capture regs, stable from GRANT+1 through done. On core_done (same-cycle-as-start ignored), latch core_result into rsp_data -> RESP.
- RESP: rsp_valid[g]=1 and rsp_data held until rsp_ready[g]. On the accept cycle: rsp_valid drops next cycle, rr_ptr=(g+1)%N_REQ -> IDLE.
- Latency, key reuse: GRANT->core_start = 1 cycle; core_done->rsp_valid = 1 cycle.
- At most one transaction in flight. Other requesters' req_ready stay 0 and their valid is held; no starvation, since each requester waits at most N_REQ-1 transactions.
- core_key_done or core_done outside KEY/RUN: ignored.
- rsp_ready on a non-granted index: ignored.
- N_REQ=1: rr_ptr is constant 0.

Optional Feature:
- Macro: AES_ARB_KEY_CACHE_EN.
- Defined: key-reuse logic as above; key expansion is skipped when the same owner has no KEY_NEW.
- Undefined: need_key is forced to 1, so every transaction goes through KEY; key_owner regs are not built.

Decomposition:
- aes.vh holds `WORD_S, `Nb, and the command bit indices `AES_CMD_ENCRYPT_BIT, `AES_CMD_KEY_NEW_BIT.
- Also in aes.vh: state encodings `AES_ARB_IDLE .. `AES_ARB_RESP.
- One sub-module: rr_arbiter (N_REQ request vector + pointer -> one-hot grant + index, combinational).

Test Plan:
- Single op: req0 key=000102..0f, data=00112233..ff, ENCRYPT -> one core_key_start, one core_start; rsp_valid[0] with rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a.
- Key reuse: a second req0 encrypt without KEY_NEW -> no core_key_start with CACHE_EN, one without; same ciphertext.
- Fairness: req0 and req1 both held valid for 4 transactions -> grant order 0,1,0,1 and key expansion on every grant.
- Backpressure: hold rsp_ready[1]=0 for 10 cycles -> rsp_valid[1] and rsp_data stable, no new grant, req_ready all 0.
- Decrypt: req1 key=000102..0f, data=69c4e0d8..c55a, decrypt -> rsp_data=00112233445566778899aabbccddeeff.
- Reset during RUN: aresetn=0 for 2 cycles -> all outputs 0; a later request is served correctly with key expansion forced.
